qtable_update_param: RTL and testbench

QTABLE_UPDATE_PARAM -- requirements
Module: qtable_update_param

---
 rtl/qtable_update_param.sv | 251 +++++++++++++++++++++++++
 tb/tb_qtable_update_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qtable_update_param.sv
// qtable_update_param: neighbour / known-cluster-head table updater.
// Each accepted packet updates the neighbour table and then the known-CH
// list. Each table is searched linearly, one entry per cycle.
// Optional build macro: QTABLE_BESTQ_EN adds best_id/best_qvalue tracking
// of the neighbour with the largest Q-value.
module qtable_update_param #(
   parameter int WORD_WIDTH = 16,
   parameter int NBR_DEPTH  = 16,
   parameter int KCH_DEPTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pkt_valid,
   output logic                  pkt_ready,
   input  logic [WORD_WIDTH-1:0] f_source_id,
   input  logic [WORD_WIDTH-1:0] f_cluster_id,
   input  logic [WORD_WIDTH-1:0] f_energy,
   input  logic [WORD_WIDTH-1:0] f_qvalue,
   input  logic [2:0]            f_packet_type,
   input  logic [7:0]            rd_idx,
   output logic [WORD_WIDTH-1:0] rd_id,
   output logic [WORD_WIDTH-1:0] rd_cluster,
   output logic [WORD_WIDTH-1:0] rd_energy,
   output logic [WORD_WIDTH-1:0] rd_qvalue,
   input  logic [7:0]            kch_rd_idx,
   output logic [WORD_WIDTH-1:0] kch_rd_id,
   output logic [7:0]            nbr_count,
   output logic [7:0]            kch_count,
   output logic                  nbr_hit,
   output logic                  nbr_ovf,
   output logic                  kch_ovf,
   output logic                  done
`ifdef QTABLE_BESTQ_EN
   ,
   output logic [WORD_WIDTH-1:0] best_id,
   output logic [WORD_WIDTH-1:0] best_qvalue
`endif
);
   localparam int NI = (NBR_DEPTH > 1) ? $clog2(NBR_DEPTH) : 1;
   localparam int KI = (KCH_DEPTH > 1) ? $clog2(KCH_DEPTH) : 1;

   // 9-bit counts/indices so a full 256-entry table is representable
   typedef logic [8:0] cnt_t;
   typedef logic [WORD_WIDTH-1:0] word_t;

   typedef enum logic [2:0] {
      S_IDLE, S_SRCH_N, S_WR_N, S_SRCH_K, S_WR_K, S_DONE
`ifdef QTABLE_BESTQ_EN
      , S_SCAN
`endif
   } state_t;

   state_t  state_q;
   logic    ready_q, done_q, hit_q, novf_q, kovf_q, nmatch_q, kmatch_q;
   cnt_t    n_q, k_q, nbr_cnt_q, kch_cnt_q;
   word_t   src_q, clu_q, en_q, qv_q;
   logic [2:0] typ_q;
   word_t   nbr_id_q [NBR_DEPTH];
   word_t   nbr_cl_q [NBR_DEPTH];
   word_t   nbr_en_q [NBR_DEPTH];
   word_t   nbr_qv_q [NBR_DEPTH];
   word_t   kch_id_q [KCH_DEPTH];
`ifdef QTABLE_BESTQ_EN
   logic [NI-1:0] best_idx_q;
   word_t         best_id_q, best_qv_q;
   assign best_id     = best_id_q;
   assign best_qvalue = best_qv_q;
`endif

   assign pkt_ready = ready_q;
   assign done      = done_q;
   assign nbr_hit   = hit_q;
   assign nbr_ovf   = novf_q;
   assign kch_ovf   = kovf_q;
   // A full 256-entry table reports 255 on the 8-bit count port
   assign nbr_count = nbr_cnt_q[8] ? 8'hFF : nbr_cnt_q[7:0];
   assign kch_count = kch_cnt_q[8] ? 8'hFF : kch_cnt_q[7:0];

   // Combinational read ports; out-of-range indices read as zero
   always_comb begin
      rd_id      = '0;
      rd_cluster = '0;
      rd_energy  = '0;
      rd_qvalue  = '0;
      kch_rd_id  = '0;
      for (int i = 0; i < NBR_DEPTH; i++) begin
         if (rd_idx == 8'(i) && cnt_t'(i) < nbr_cnt_q) begin
            rd_id      = nbr_id_q[i];
            rd_cluster = nbr_cl_q[i];
            rd_energy  = nbr_en_q[i];
            rd_qvalue  = nbr_qv_q[i];
         end
      end
      for (int i = 0; i < KCH_DEPTH; i++)
         if (kch_rd_idx == 8'(i) && cnt_t'(i) < kch_cnt_q)
            kch_rd_id = kch_id_q[i];
   end

   // Control FSM with registered outputs and table storage
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         hit_q     <= 1'b0;
         novf_q    <= 1'b0;
         kovf_q    <= 1'b0;
         nmatch_q  <= 1'b0;
         kmatch_q  <= 1'b0;
         n_q       <= '0;
         k_q       <= '0;
         nbr_cnt_q <= '0;
         kch_cnt_q <= '0;
         src_q     <= '0;
         clu_q     <= '0;
         en_q      <= '0;
         qv_q      <= '0;
         typ_q     <= '0;
         for (int i = 0; i < NBR_DEPTH; i++) begin
            nbr_id_q[i] <= '0;
            nbr_cl_q[i] <= '0;
            nbr_en_q[i] <= '0;
            nbr_qv_q[i] <= '0;
         end
         for (int i = 0; i < KCH_DEPTH; i++)
            kch_id_q[i] <= '0;
`ifdef QTABLE_BESTQ_EN
         best_idx_q <= '0;
         best_id_q  <= '0;
         best_qv_q  <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (pkt_valid) begin
                  src_q   <= f_source_id;
                  clu_q   <= f_cluster_id;
                  en_q    <= f_energy;
                  qv_q    <= f_qvalue;
                  typ_q   <= f_packet_type;
                  n_q     <= '0;
                  k_q     <= '0;
                  ready_q <= 1'b0;
                  state_q <= S_SRCH_N;
               end
            end
            S_SRCH_N: begin
               if (typ_q == 3'd0) begin
                  hit_q   <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (n_q == nbr_cnt_q) begin
                  nmatch_q <= 1'b0;
                  state_q  <= S_WR_N;
               end else if (nbr_id_q[n_q[NI-1:0]] == src_q) begin
                  nmatch_q <= 1'b1;
                  state_q  <= S_WR_N;
               end else begin
                  n_q <= n_q + 9'd1;
               end
            end
            S_WR_N: begin
               state_q <= S_SRCH_K;
               if (nmatch_q) begin
                  nbr_cl_q[n_q[NI-1:0]] <= clu_q;
                  nbr_en_q[n_q[NI-1:0]] <= en_q;
                  nbr_qv_q[n_q[NI-1:0]] <= qv_q;
                  hit_q <= 1'b1;
               end else begin
                  hit_q <= 1'b0;
                  if (nbr_cnt_q != cnt_t'(NBR_DEPTH)) begin
                     nbr_id_q[nbr_cnt_q[NI-1:0]] <= src_q;
                     nbr_cl_q[nbr_cnt_q[NI-1:0]] <= clu_q;
                     nbr_en_q[nbr_cnt_q[NI-1:0]] <= en_q;
                     nbr_qv_q[nbr_cnt_q[NI-1:0]] <= qv_q;
                     nbr_cnt_q <= nbr_cnt_q + 9'd1;
                  end else begin
                     novf_q <= 1'b1;
                  end
               end
`ifdef QTABLE_BESTQ_EN
               if (nmatch_q) begin
                  if (n_q[NI-1:0] == best_idx_q) begin
                     // Current best lost value: the new best can be anywhere
                     if (qv_q < best_qv_q) begin
                        n_q     <= '0;
                        state_q <= S_SCAN;
                     end else begin
                        best_qv_q <= qv_q;
                     end
                  end else if (qv_q > best_qv_q ||
                               (qv_q == best_qv_q && n_q[NI-1:0] < best_idx_q)) begin
                     best_idx_q <= n_q[NI-1:0];
                     best_id_q  <= src_q;
                     best_qv_q  <= qv_q;
                  end
               end else if (nbr_cnt_q != cnt_t'(NBR_DEPTH)) begin
                  // Appended entry has the highest index, so it wins only strictly
                  if (nbr_cnt_q == '0 || qv_q > best_qv_q) begin
                     best_idx_q <= nbr_cnt_q[NI-1:0];
                     best_id_q  <= src_q;
                     best_qv_q  <= qv_q;
                  end
               end
`endif
            end
            S_SRCH_K: begin
               if (k_q == kch_cnt_q) begin
                  kmatch_q <= 1'b0;
                  state_q  <= S_WR_K;
               end else if (kch_id_q[k_q[KI-1:0]] == clu_q) begin
                  kmatch_q <= 1'b1;
                  state_q  <= S_WR_K;
               end else begin
                  k_q <= k_q + 9'd1;
               end
            end
            S_WR_K: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
               // Cluster ID 0 means "no cluster head" and is never recorded
               if (!kmatch_q && clu_q != '0) begin
                  if (kch_cnt_q != cnt_t'(KCH_DEPTH)) begin
                     kch_id_q[kch_cnt_q[KI-1:0]] <= clu_q;
                     kch_cnt_q <= kch_cnt_q + 9'd1;
                  end else begin
                     kovf_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               ready_q <= 1'b1;
               state_q <= S_IDLE;
            end
`ifdef QTABLE_BESTQ_EN
            S_SCAN: begin
               if (n_q == '0 || nbr_qv_q[n_q[NI-1:0]] > best_qv_q) begin
                  best_idx_q <= n_q[NI-1:0];
                  best_id_q  <= nbr_id_q[n_q[NI-1:0]];
                  best_qv_q  <= nbr_qv_q[n_q[NI-1:0]];
               end
               if (n_q == nbr_cnt_q - 9'd1) state_q <= S_SRCH_K;
               else                         n_q     <= n_q + 9'd1;
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qtable_update_param.sv
// Bench for qtable_update_param: directed packets, a table-level model and
// a per-cycle compare of handshake, done, counts, flags and read ports.
module tb_qtable_update_param;
   localparam int W = 16;
`ifdef QTABLE_BESTQ_EN
   localparam int ND = 3;
`else
   localparam int ND = 2;
`endif
   localparam int KD = 2;

   logic clk = 1'b0, rst = 1'b0, pkt_valid = 1'b0;
   logic pkt_ready, nbr_hit, nbr_ovf, kch_ovf, done;
   logic [W-1:0] f_source_id = '0, f_cluster_id = '0, f_energy = '0, f_qvalue = '0;
   logic [2:0] f_packet_type = '0;
   logic [7:0] rd_idx = '0, kch_rd_idx = '0;
   logic [W-1:0] rd_id, rd_cluster, rd_energy, rd_qvalue, kch_rd_id;
   logic [7:0] nbr_count, kch_count;
`ifdef QTABLE_BESTQ_EN
   logic [W-1:0] best_id, best_qvalue;
`endif

   always #5 clk = ~clk;

   qtable_update_param #(.WORD_WIDTH(W), .NBR_DEPTH(ND), .KCH_DEPTH(KD)) dut (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .f_source_id(f_source_id), .f_cluster_id(f_cluster_id), .f_energy(f_energy),
      .f_qvalue(f_qvalue), .f_packet_type(f_packet_type),
      .rd_idx(rd_idx), .rd_id(rd_id), .rd_cluster(rd_cluster), .rd_energy(rd_energy),
      .rd_qvalue(rd_qvalue), .kch_rd_idx(kch_rd_idx), .kch_rd_id(kch_rd_id),
      .nbr_count(nbr_count), .kch_count(kch_count), .nbr_hit(nbr_hit),
      .nbr_ovf(nbr_ovf), .kch_ovf(kch_ovf), .done(done)
`ifdef QTABLE_BESTQ_EN
      , .best_id(best_id), .best_qvalue(best_qvalue)
`endif
   );

   int n_vec = 0, n_err = 0, cyc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---- table-level model ----
   logic [W-1:0] m_nid [ND], m_ncl [ND], m_nen [ND], m_nq [ND];
   logic [W-1:0] m_kid [KD];
   int  m_nc, m_kc, m_t, m_L;
   bit  m_hit, m_novf, m_kovf, m_on = 1'b0, m_busy = 1'b0;
   logic [W-1:0] p_src, p_cl, p_en, p_q;
   logic [2:0] p_ty;

   function automatic int find_n(input logic [W-1:0] id);
      for (int i = 0; i < m_nc; i++) if (m_nid[i] == id) return i;
      return -1;
   endfunction
   function automatic int find_k(input logic [W-1:0] id);
      for (int i = 0; i < m_kc; i++) if (m_kid[i] == id) return i;
      return -1;
   endfunction
   // index of largest qvalue, lowest index on ties; -1 when empty
   function automatic int best_n();
      int b = -1;
      for (int i = 0; i < m_nc; i++) if (b < 0 || m_nq[i] > m_nq[b]) b = i;
      return b;
   endfunction

   function automatic int lat_of();
      int in, ik, L;
      if (p_ty == 3'd0) return 1;
      in = find_n(p_src);
      ik = find_k(p_cl);
      L = ((in < 0) ? m_nc : in) + 2 + ((ik < 0) ? m_kc : ik) + 2;
`ifdef QTABLE_BESTQ_EN
      if (in >= 0 && in == best_n() && p_q < m_nq[in]) L += m_nc;
`endif
      return L;
   endfunction

   function automatic void commit();
      int i;
      if (p_ty == 3'd0) begin m_hit = 1'b0; return; end
      i = find_n(p_src);
      if (i >= 0) begin
         m_ncl[i] = p_cl; m_nen[i] = p_en; m_nq[i] = p_q; m_hit = 1'b1;
      end else begin
         m_hit = 1'b0;
         if (m_nc < ND) begin
            m_nid[m_nc] = p_src; m_ncl[m_nc] = p_cl; m_nen[m_nc] = p_en; m_nq[m_nc] = p_q;
            m_nc++;
         end else m_novf = 1'b1;
      end
      if (p_cl != '0 && find_k(p_cl) < 0) begin
         if (m_kc < KD) begin m_kid[m_kc] = p_cl; m_kc++; end
         else m_kovf = 1'b1;
      end
   endfunction

   // one clock: advance the model on the edge, then move read indices
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_on = 1'b1; m_busy = 1'b0; m_nc = 0; m_kc = 0;
         m_hit = 1'b0; m_novf = 1'b0; m_kovf = 1'b0;
      end else if (m_on) begin
         if (!m_busy) begin
            if (pkt_valid) begin
               p_src = f_source_id; p_cl = f_cluster_id; p_en = f_energy;
               p_q = f_qvalue; p_ty = f_packet_type;
               m_L = lat_of(); m_t = 0; m_busy = 1'b1;
            end
         end else begin
            m_t++;
            if (m_t == m_L + 1) begin commit(); m_busy = 1'b0; end
         end
      end
      cyc++;
      #1;
      rd_idx     = 8'(cyc % (ND + 2));
      kch_rd_idx = 8'(cyc % (KD + 2));
   endtask

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (m_on) begin
         chk("pkt_ready", 32'(pkt_ready), 32'(!m_busy));
         chk("done", 32'(done), 32'(m_busy && m_t == m_L));
         if (!m_busy) begin
            chk("nbr_count", 32'(nbr_count), 32'(m_nc));
            chk("kch_count", 32'(kch_count), 32'(m_kc));
            chk("nbr_hit", 32'(nbr_hit), 32'(m_hit));
            chk("nbr_ovf", 32'(nbr_ovf), 32'(m_novf));
            chk("kch_ovf", 32'(kch_ovf), 32'(m_kovf));
            chk("rd_id", 32'(rd_id), (int'(rd_idx) < m_nc) ? 32'(m_nid[rd_idx]) : 32'd0);
            chk("rd_cluster", 32'(rd_cluster), (int'(rd_idx) < m_nc) ? 32'(m_ncl[rd_idx]) : 32'd0);
            chk("rd_energy", 32'(rd_energy), (int'(rd_idx) < m_nc) ? 32'(m_nen[rd_idx]) : 32'd0);
            chk("rd_qvalue", 32'(rd_qvalue), (int'(rd_idx) < m_nc) ? 32'(m_nq[rd_idx]) : 32'd0);
            chk("kch_rd_id", 32'(kch_rd_id), (int'(kch_rd_idx) < m_kc) ? 32'(m_kid[kch_rd_idx]) : 32'd0);
`ifdef QTABLE_BESTQ_EN
            chk("best_id", 32'(best_id), (m_nc > 0) ? 32'(m_nid[best_n()]) : 32'd0);
            chk("best_qvalue", 32'(best_qvalue), (m_nc > 0) ? 32'(m_nq[best_n()]) : 32'd0);
`endif
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
   endtask

   // send one packet; lat = cycles from accept edge to done high (-1 if none)
   task automatic send(input logic [W-1:0] s, c, e, q, input logic [2:0] ty, output int lat);
      int g = 0;
      while (m_busy && g < 1000) begin tick(); g++; end
      f_source_id = s; f_cluster_id = c; f_energy = e; f_qvalue = q; f_packet_type = ty;
      pkt_valid = 1'b1;
      tick();
      // scramble fields and hold valid one more cycle: both must be ignored
      f_source_id = W'($urandom); f_cluster_id = W'($urandom);
      f_energy = W'($urandom); f_qvalue = W'($urandom); f_packet_type = 3'($urandom);
      lat = -1;
      for (int i = 1; i <= 1000; i++) begin
         tick();
         if (i == 1) pkt_valid = 1'b0;
         if (done && lat < 0) lat = i;
         if (!m_busy) break;
      end
      if (m_busy) chk("packet_timeout", 32'(m_busy), 32'd0);
      tick();
   endtask

   initial begin
      int lat;
      do_reset();
      chk("reset_ready", 32'(pkt_ready), 32'd1);
      chk("reset_nbr_count", 32'(nbr_count), 32'd0);
      chk("reset_done", 32'(done), 32'd0);

      // first packet into empty tables
      send(16'd5, 16'd9, 16'd100, 16'd40, 3'd1, lat);
      chk("lat_first", 32'(lat), 32'd4);
      rd_idx = 8'd0; #1;
      chk("e0_id", 32'(rd_id), 32'd5);
      chk("e0_cluster", 32'(rd_cluster), 32'd9);
      chk("e0_energy", 32'(rd_energy), 32'd100);
      chk("e0_qvalue", 32'(rd_qvalue), 32'd40);
      chk("hit_first", 32'(nbr_hit), 32'd0);
      chk("kch_count_first", 32'(kch_count), 32'd1);

      // same source again: in-place update, both searches hit index 0
      send(16'd5, 16'd9, 16'd80, 16'd55, 3'd1, lat);
      chk("lat_hit", 32'(lat), 32'd4);
      rd_idx = 8'd0; #1;
      chk("upd_energy", 32'(rd_energy), 32'd80);
      chk("upd_qvalue", 32'(rd_qvalue), 32'd55);
      chk("hit_second", 32'(nbr_hit), 32'd1);
      chk("nbr_count_second", 32'(nbr_count), 32'd1);

      // type 0 packet leaves everything alone
      send(16'd7, 16'd3, 16'd1, 16'd1, 3'd0, lat);
      chk("lat_type0", 32'(lat), 32'd1);
      chk("type0_count", 32'(nbr_count), 32'd1);
      chk("type0_hit", 32'(nbr_hit), 32'd0);

      // neighbour overflow with cluster 0
      do_reset();
      for (int i = 1; i <= ND + 1; i++) begin
         send(W'(i), 16'd0, 16'd10, 16'd20, 3'd2, lat);
         chk("lat_fill", 32'(lat), 32'(4 + (i - 1)));
      end
      chk("ovf_count", 32'(nbr_count), 32'(ND));
      chk("ovf_flag", 32'(nbr_ovf), 32'd1);
      chk("ovf_kch_count", 32'(kch_count), 32'd0);
      rd_idx = 8'd1; #1;
      chk("ovf_e1_id", 32'(rd_id), 32'd2);
      rd_idx = 8'(ND); #1;
      chk("oob_read", 32'(rd_id), 32'd0);

      // known-CH overflow; overflow flag stays sticky
      send(16'd1, 16'd21, 16'd1, 16'd1, 3'd1, lat);
      send(16'd2, 16'd22, 16'd1, 16'd1, 3'd1, lat);
      send(16'd1, 16'd23, 16'd1, 16'd1, 3'd1, lat);
      chk("kovf_count", 32'(kch_count), 32'd2);
      chk("kovf_flag", 32'(kch_ovf), 32'd1);
      send(16'd1, 16'd21, 16'd1, 16'd1, 3'd1, lat);
      chk("kovf_sticky", 32'(kch_ovf), 32'd1);

      // reset during neighbour search aborts the packet
      f_source_id = 16'd4; f_cluster_id = 16'd6; f_packet_type = 3'd1; pkt_valid = 1'b1;
      tick();
      pkt_valid = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("abort_ready", 32'(pkt_ready), 32'd1);
      for (int i = 0; i < 8; i++) tick();
      chk("abort_count", 32'(nbr_count), 32'd0);

`ifdef QTABLE_BESTQ_EN
      do_reset();
      send(16'd11, 16'd0, 16'd1, 16'd10, 3'd1, lat);
      send(16'd12, 16'd0, 16'd1, 16'd30, 3'd1, lat);
      send(16'd13, 16'd0, 16'd1, 16'd20, 3'd1, lat);
      chk("best_id_30", 32'(best_id), 32'd12);
      send(16'd12, 16'd0, 16'd1, 16'd5, 3'd1, lat);
      chk("lat_rescan", 32'(lat), 32'd8);
      chk("best_id_20", 32'(best_id), 32'd13);
      chk("best_q_20", 32'(best_qvalue), 32'd20);
`endif

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
